// File: rtl/mem_wb_elastic_pkg.sv
// Shared definitions for the elastic MEM->WB pipeline register: NOP encodings,
// write-enable constants and payload width helpers.
package mem_wb_elastic_pkg;

    localparam int unsigned NOP_REG_ADDR = 0;
    localparam int unsigned ZERO_WORD    = 0;

    localparam logic WE_ON  = 1'b1;
    localparam logic WE_OFF = 1'b0;

    // Per-lane field is {wreg, wdata, wd}; HI/LO adds {whilo, hi, lo} once.
    function automatic int lane_field_w(input int addr_w, input int data_w);
        return addr_w + data_w + 1;
    endfunction

    function automatic int payload_w(input int lanes, input int addr_w, input int data_w);
        return lanes * lane_field_w(addr_w, data_w) + 2 * data_w + 1;
    endfunction

endpackage

// File: rtl/mem_wb_elastic_wb_skid_slot.sv
// One storage entry of the elastic register: a valid bit plus a flat payload.
// Clear wins over load so a flush always empties the entry.
module wb_skid_slot #(
    parameter int PAY_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [PAY_W-1:0] data_i,
    output logic             valid_o,
    output logic [PAY_W-1:0] data_o
);

    logic             valid_q;
    logic [PAY_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mem_wb_elastic.sv
// MEM->WB pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and a saturating writeback-stall counter.
module mem_wb_elastic
    import mem_wb_elastic_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 1,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*ADDR_W-1:0] in_wd,
    input  logic [LANES*DATA_W-1:0] in_wdata,
    input  logic [LANES-1:0]        in_wreg,
    input  logic [DATA_W-1:0]       in_hi,
    input  logic [DATA_W-1:0]       in_lo,
    input  logic                    in_whilo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ADDR_W-1:0] wb_wd,
    output logic [LANES*DATA_W-1:0] wb_wdata,
    output logic [LANES-1:0]        wb_wreg,
    output logic [DATA_W-1:0]       wb_hi,
    output logic [DATA_W-1:0]       wb_lo,
    output logic                    wb_whilo,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam int PAY_W = payload_w(LANES, ADDR_W, DATA_W);

    logic             main_valid, skid_valid;
    logic [PAY_W-1:0] main_data, skid_data, in_data, main_load_data;
    logic             main_load, main_clear, main_src_skid;
    logic             skid_load, skid_clear;
    logic             accept, retire;

    logic [LANES*ADDR_W-1:0] main_wd;
    logic [LANES*DATA_W-1:0] main_wdata;
    logic [LANES-1:0]        main_wreg;
    logic [DATA_W-1:0]       main_hi, main_lo;
    logic                    main_whilo;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign in_ready  = !skid_valid && !rst;
    assign out_valid = main_valid;
    assign accept    = in_valid && in_ready;
    assign retire    = main_valid && out_ready;

    assign in_data        = {in_whilo, in_hi, in_lo, in_wreg, in_wdata, in_wd};
    assign main_load_data = main_src_skid ? skid_data : in_data;

    // The skid only fills while main is full, so main is never empty with skid valid.
    always_comb begin
        main_load     = 1'b0;
        main_clear    = 1'b0;
        main_src_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (!main_valid) begin
            main_load = accept;
        end else if (retire) begin
            if (skid_valid) begin
                main_load     = 1'b1;
                main_src_skid = 1'b1;
                skid_clear    = 1'b1;
            end else if (accept) begin
                main_load = 1'b1;
            end else begin
                main_clear = 1'b1;
            end
        end else begin
            skid_load = accept;
        end
    end

    wb_skid_slot #(.PAY_W(PAY_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (main_load),
        .clear_i (main_clear),
        .data_i  (main_load_data),
        .valid_o (main_valid),
        .data_o  (main_data)
    );

    wb_skid_slot #(.PAY_W(PAY_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );

    assign {main_whilo, main_hi, main_lo, main_wreg, main_wdata, main_wd} = main_data;

    // An empty stage presents a NOP: register 0, zero data, all enables off.
    assign wb_wd    = main_valid ? main_wd    : {LANES{ADDR_W'(NOP_REG_ADDR)}};
    assign wb_wdata = main_valid ? main_wdata : {LANES{DATA_W'(ZERO_WORD)}};
    assign wb_hi    = main_valid ? main_hi    : DATA_W'(ZERO_WORD);
    assign wb_lo    = main_valid ? main_lo    : DATA_W'(ZERO_WORD);
    assign wb_wreg  = main_valid ? main_wreg  : {LANES{WE_OFF}};
    assign wb_whilo = main_valid ? main_whilo : WE_OFF;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Flush deliberately leaves the counter alone; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Directed self-checking bench for mem_wb_elastic with two lanes and a 4-bit
// stall counter so lane independence and saturation are both reachable.
module tb_mem_wb_elastic;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int LANES  = 2;
    localparam int CNT_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*ADDR_W-1:0] in_wd;
    logic [LANES*DATA_W-1:0] in_wdata;
    logic [LANES-1:0]        in_wreg;
    logic [DATA_W-1:0]       in_hi, in_lo;
    logic                    in_whilo;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*ADDR_W-1:0] wb_wd;
    logic [LANES*DATA_W-1:0] wb_wdata;
    logic [LANES-1:0]        wb_wreg;
    logic [DATA_W-1:0]       wb_hi, wb_lo;
    logic                    wb_whilo;
    logic [CNT_W-1:0]        stall_cnt;

    int checks   = 0;
    int failures = 0;

    mem_wb_elastic #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_wd     (in_wd),
        .in_wdata  (in_wdata),
        .in_wreg   (in_wreg),
        .in_hi     (in_hi),
        .in_lo     (in_lo),
        .in_whilo  (in_whilo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wb_wd     (wb_wd),
        .wb_wdata  (wb_wdata),
        .wb_wreg   (wb_wreg),
        .wb_hi     (wb_hi),
        .wb_lo     (wb_lo),
        .wb_whilo  (wb_whilo),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [9:0] wd, input logic [63:0] wdata,
                                 input logic [1:0] wreg, input logic [31:0] hi,
                                 input logic [31:0] lo, input logic whilo);
        in_valid = v;
        in_wd    = wd;
        in_wdata = wdata;
        in_wreg  = wreg;
        in_hi    = hi;
        in_lo    = lo;
        in_whilo = whilo;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0);
        tick();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++;
        if ({wb_wd, wb_wdata, wb_wreg, wb_hi, wb_lo, wb_whilo} !== '0) begin
            failures++; $display("[TB] FAIL reset_wb_zero: got wd=%0h wdata=%0h wreg=%0b expected all zero", wb_wd, wb_wdata, wb_wreg);
        end
        checks++;
        if (stall_cnt !== 4'd0) begin failures++; $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_release_in_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_single();
        doReset();
        out_ready = 1'b1;
        applyStimulus(1'b1, 10'd5, 64'h0000_0000_DEAD_BEEF, 2'b01, '0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_out_valid: got %0b expected 1", out_valid); end
        checks++;
        if (wb_wd !== 10'd5) begin failures++; $display("[TB] FAIL single_wd: got %0h expected 5", wb_wd); end
        checks++;
        if (wb_wdata !== 64'h0000_0000_DEAD_BEEF) begin failures++; $display("[TB] FAIL single_wdata: got %0h expected deadbeef", wb_wdata); end
        checks++;
        if (wb_wreg !== 2'b01) begin failures++; $display("[TB] FAIL single_wreg: got %0b expected 01", wb_wreg); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_in_ready: got %0b expected 1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || wb_wd !== 10'd0 || wb_wdata !== 64'd0) begin
            failures++; $display("[TB] FAIL single_drain: got valid=%0b wd=%0h wdata=%0h expected 0/0/0", out_valid, wb_wd, wb_wdata);
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        out_ready = 1'b0;
        applyStimulus(1'b1, 10'd1, 64'hA, 2'b01, '0, '0, 1'b0);
        tick();
        applyStimulus(1'b1, 10'd2, 64'hB, 2'b01, '0, '0, 1'b0);
        tick();
        applyStimulus(1'b1, 10'd3, 64'hC, 2'b01, '0, '0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_full_in_ready: got %0b expected 0", in_ready); end
        tick();
        tick();
        checks++;
        if (wb_wdata !== 64'hA || in_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL b2b_hold_A: got wdata=%0h in_ready=%0b expected a/0", wb_wdata, in_ready);
        end
        checks++;
        if (stall_cnt !== 4'd3) begin failures++; $display("[TB] FAIL b2b_stall_cnt: got %0d expected 3", stall_cnt); end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || wb_wdata !== 64'hB || wb_wd !== 10'd2) begin
            failures++; $display("[TB] FAIL b2b_out_B: got valid=%0b wdata=%0h expected 1/b", out_valid, wb_wdata);
        end
        tick();
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || wb_wdata !== 64'hC || wb_wd !== 10'd3) begin
            failures++; $display("[TB] FAIL b2b_out_C: got valid=%0b wdata=%0h expected 1/c", out_valid, wb_wdata);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 4'd3) begin
            failures++; $display("[TB] FAIL b2b_drained: got valid=%0b stall_cnt=%0d expected 0/3", out_valid, stall_cnt);
        end
    endtask

    task automatic test_flush();
        doReset();
        out_ready = 1'b0;
        applyStimulus(1'b1, 10'd1, 64'h11, 2'b11, 32'h5, 32'h6, 1'b1);
        tick();
        applyStimulus(1'b1, 10'd2, 64'h22, 2'b11, 32'h7, 32'h8, 1'b1);
        tick();
        flush = 1'b1;
        applyStimulus(1'b1, 10'd4, 64'h44, 2'b11, 32'h9, 32'hA, 1'b1);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || wb_wreg !== 2'b00 || wb_whilo !== 1'b0) begin
            failures++; $display("[TB] FAIL flush_outputs: got valid=%0b wreg=%0b whilo=%0b expected 0/00/0", out_valid, wb_wreg, wb_whilo);
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_in_ready: got %0b expected 1", in_ready); end
        checks++;
        if (stall_cnt !== 4'd2) begin failures++; $display("[TB] FAIL flush_keeps_cnt: got %0d expected 2", stall_cnt); end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_no_capture: got %0b expected 0", out_valid); end
    endtask

    task automatic test_lanes();
        doReset();
        out_ready = 1'b1;
        applyStimulus(1'b1, {5'd7, 5'd3}, {32'h7777_0000, 32'h3333_0000}, 2'b01, 32'h1, 32'h2, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0);
        checks++;
        if (wb_wreg !== 2'b01 || wb_whilo !== 1'b1) begin
            failures++; $display("[TB] FAIL lanes_enables: got wreg=%0b whilo=%0b expected 01/1", wb_wreg, wb_whilo);
        end
        checks++;
        if (wb_hi !== 32'h1 || wb_lo !== 32'h2) begin
            failures++; $display("[TB] FAIL lanes_hilo: got hi=%0h lo=%0h expected 1/2", wb_hi, wb_lo);
        end
        checks++;
        if (wb_wd !== {5'd7, 5'd3} || wb_wdata !== {32'h7777_0000, 32'h3333_0000}) begin
            failures++; $display("[TB] FAIL lanes_payload: got wd=%0h wdata=%0h expected e3/777700003333_0000", wb_wd, wb_wdata);
        end
        tick();
    endtask

    task automatic test_saturation();
        doReset();
        out_ready = 1'b0;
        applyStimulus(1'b1, 10'd9, 64'h99, 2'b01, 32'h3, 32'h4, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0);
        repeat (14) tick();
        checks++;
        if (stall_cnt !== 4'd14) begin failures++; $display("[TB] FAIL sat_cnt_14: got %0d expected 14", stall_cnt); end
        repeat (6) tick();
        checks++;
        if (stall_cnt !== 4'd15) begin failures++; $display("[TB] FAIL sat_cnt_15: got %0d expected 15", stall_cnt); end
        rst = 1'b1;
        tick();
        checks++;
        if (stall_cnt !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL sat_reset: got cnt=%0d valid=%0b in_ready=%0b expected 0/0/0", stall_cnt, out_valid, in_ready);
        end
        checks++;
        if ({wb_wd, wb_wdata, wb_wreg, wb_hi, wb_lo, wb_whilo} !== '0) begin
            failures++; $display("[TB] FAIL sat_reset_wb: got wd=%0h wdata=%0h hi=%0h expected all zero", wb_wd, wb_wdata, wb_hi);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset_skid_full();
        doReset();
        out_ready = 1'b0;
        applyStimulus(1'b1, 10'd1, 64'h1, 2'b01, '0, '0, 1'b0);
        tick();
        applyStimulus(1'b1, 10'd2, 64'h2, 2'b01, '0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL rstfull_in_ready: got %0b expected 0", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstfull_out_valid: got %0b expected 0", out_valid); end
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rstfull_release: got %0b expected 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstfull_stale_%0d: got %0b expected 0", i, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_lanes();
        test_saturation();
        test_reset_skid_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
